// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 3x3 convolution window generator:
// default geometry, window FSM state encoding and lane index constants.
package conv_pkg;

  // Default pixel width and window size used by the generator parameters.
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_F           = 3;

  // A paced window is held for one cycle per tap plus two cycles for the
  // conv unit's clear and result stages.
  localparam int DEF_CONV_CYCLES = DEF_F * DEF_F + 2;

  // Lane positions inside a row bus: left is the oldest column (c-2),
  // right is the column of the pixel that completed the window (c).
  localparam int LANE_LEFT  = 0;
  localparam int LANE_MID   = 1;
  localparam int LANE_RIGHT = 2;

  // Window generator states.
  //   IDLE : nothing accepted last cycle, no window pending
  //   FILL : a pixel was accepted that does not complete a window
  //   EMIT : a valid window is on the row buses
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } win_state_t;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel storage for the window generator.
// Combinational read and registered write at the same address, so a read in
// the accepting cycle returns the value stored before that cycle's write.
// Contents are deliberately not reset; the generator's fill guard keeps any
// stale row data from ever reaching a valid window.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Store the new pixel for this column; the old value has already been read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator for the conv unit.
//
// Takes a raster-order pixel stream (valid/ready), keeps two line buffers and
// a 3x3 register window, and presents one window per valid output position on
// the image0 (two rows up), image1 (one row up) and image2 (current row) buses.
// Lane 0 of each bus is column c-2, lane 2 is column c.
//
// Optional build macro CONV_WINGEN_PACE_EN: when defined, each window is held
// for CONV_CYCLES cycles and consumed when an internal counter expires,
// conv_rst pulses in the first cycle of every new window and win_ready is
// ignored. When undefined, conv_rst is tied low and a window is consumed on
// win_valid && win_ready.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int F           = DEF_F,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [F*DATA_WIDTH-1:0] image0,
  output logic [F*DATA_WIDTH-1:0] image1,
  output logic [F*DATA_WIDTH-1:0] image2,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    conv_rst,
  output logic                    frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Geometry that the window datapath cannot handle stops elaboration.
  generate
    if (F != 3) begin : g_bad_window_size
      $error("conv_window_gen: only a 3x3 window (F=3) is supported");
    end
    if ((IMG_W < F) || (IMG_H < F)) begin : g_bad_image_size
      $error("conv_window_gen: IMG_W and IMG_H must be at least F");
    end
    if (CONV_CYCLES < 1) begin : g_bad_conv_cycles
      $error("conv_window_gen: CONV_CYCLES must be at least 1");
    end
  endgenerate

  win_state_t state;
  win_state_t state_next;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic accept;
  logic consume;
  logic completes;
  logic at_last_pos;
  logic last_win;

  logic [DATA_WIDTH-1:0] lb0_rd;
  logic [DATA_WIDTH-1:0] lb1_rd;

  logic [F-1:0][DATA_WIDTH-1:0] win0;
  logic [F-1:0][DATA_WIDTH-1:0] win1;
  logic [F-1:0][DATA_WIDTH-1:0] win2;

  assign win_valid = (state == EMIT);

  // The source may hand over a pixel whenever no window is pending or the
  // pending one leaves this very cycle, giving one window per cycle when the
  // consumer keeps up.
  assign in_ready = !win_valid || consume;
  assign accept   = in_valid && in_ready;

  // Windows never straddle rows: the first two rows and the first two
  // columns of every row only fill the register window.
  assign completes   = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign at_last_pos = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

`ifdef CONV_WINGEN_PACE_EN
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  logic [CNT_W-1:0] pace_cnt;
  logic             unused_win_ready;

  assign unused_win_ready = win_ready;
  assign consume          = win_valid && (pace_cnt == CNT_W'(CONV_CYCLES - 1));

  // Count the cycles the current window has been on the buses; a freshly
  // completed window restarts the count from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace_cnt <= '0;
    end else if (completes) begin
      pace_cnt <= '0;
    end else if (win_valid) begin
      pace_cnt <= pace_cnt + 1'b1;
    end
  end

  // Clear the conv unit's accumulator in the first cycle of each new window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_rst <= 1'b0;
    end else begin
      conv_rst <= completes;
    end
  end
`else
  assign consume  = win_valid && win_ready;
  assign conv_rst = 1'b0;
`endif

  // Two rows of history: lb1 holds the previous row, lb0 the row before.
  // On each accept the older row moves down and the new pixel takes its place.
  line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_W)
  ) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .wdata(lb1_rd),
    .rdata(lb0_rd)
  );

  line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (IMG_W)
  ) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .wdata(in_pixel),
    .rdata(lb1_rd)
  );

  // Window state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A completing accept always lands in EMIT, even when the previous window
  // leaves in the same cycle; otherwise EMIT holds until its window is consumed.
  always_comb begin
    state_next = state;
    case (state)
      EMIT: begin
        if (completes) begin
          state_next = EMIT;
        end else if (consume) begin
          state_next = accept ? FILL : IDLE;
        end else begin
          state_next = EMIT;
        end
      end
      default: begin
        if (completes) begin
          state_next = EMIT;
        end else if (accept) begin
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Raster position of the next pixel; wrapping the last row starts a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        if (row == ROW_W'(IMG_H - 1)) begin
          row <= '0;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift the register window one column left and load the new right column
  // from the two line buffers and the incoming pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win0 <= '0;
      win1 <= '0;
      win2 <= '0;
    end else if (accept) begin
      win0[LANE_LEFT]  <= win0[LANE_MID];
      win0[LANE_MID]   <= win0[LANE_RIGHT];
      win0[LANE_RIGHT] <= lb0_rd;
      win1[LANE_LEFT]  <= win1[LANE_MID];
      win1[LANE_MID]   <= win1[LANE_RIGHT];
      win1[LANE_RIGHT] <= lb1_rd;
      win2[LANE_LEFT]  <= win2[LANE_MID];
      win2[LANE_MID]   <= win2[LANE_RIGHT];
      win2[LANE_RIGHT] <= in_pixel;
    end
  end

  // Remember whether the window on the buses is the frame's last one and
  // pulse frame_done the cycle after that window is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_win   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= consume && last_win;
      if (completes) begin
        last_win <= at_last_pos;
      end
    end
  end

  assign image0 = win0;
  assign image1 = win1;
  assign image2 = win2;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 5x4 image where each pixel
// value is row*16+col (frame two of the back-to-back run adds 0x40).
// With CONV_WINGEN_PACE_EN defined the paced sequence runs instead of the
// handshake scenarios.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] image0;
  logic [23:0] image1;
  logic [23:0] image2;
  logic        win_valid;
  logic        win_ready;
  logic        conv_rst;
  logic        frame_done;

  int checksTotal;
  int checksPassed;
  int windowCount;
  int frameDoneCount;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_WIDTH (DW),
    .F          (3),
    .IMG_W      (W),
    .IMG_H      (H),
    .CONV_CYCLES(11)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .image0    (image0),
    .image1    (image1),
    .image2    (image2),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .conv_rst  (conv_rst),
    .frame_done(frame_done)
  );

  // Count consumed windows and frame_done pulses mid-cycle, where both the
  // registered outputs and the bench-driven win_ready are stable.
  initial begin
    windowCount    = 0;
    frameDoneCount = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (win_valid && win_ready) windowCount++;
        if (frame_done) frameDoneCount++;
      end
    end
  end

  // Hard stop in case the run gets stuck.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pixel value for raster index idx within a frame, plus a frame offset.
  function automatic logic [7:0] pix(input int idx, input int off);
    int r;
    int c;
    r = idx / W;
    c = idx % W;
    return 8'((r * 16) + c + off);
  endfunction

  // Compare one value, count it and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; report whether the pixel is taken at the
  // coming edge, then return 1 ns after that edge with outputs settled.
  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic r,
                               output logic acc);
    in_valid  = v;
    in_pixel  = p;
    win_ready = r;
    #2;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

`ifdef CONV_WINGEN_PACE_EN
  // Sum of all nine lanes as a conv unit with an all-ones filter would see it.
  function automatic int laneSum();
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      s += int'($signed(image0[k*DW +: DW]));
      s += int'($signed(image1[k*DW +: DW]));
      s += int'($signed(image2[k*DW +: DW]));
    end
    return s;
  endfunction

  // Paced mode: win_ready stays low, windows are held for 11 cycles each.
  task automatic runPace();
    logic acc;
    int   calls;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, pix(i, 0), 1'b0, acc);
      checkOutput($sformatf("pace_fill_accept_%0d", i), acc, 1'b1);
    end
    checkOutput("pace_w1_valid", win_valid, 1'b1);
    checkOutput("pace_w1_conv_rst", conv_rst, 1'b1);
    checkOutput("pace_w1_image2", image2, 24'h222120);
    checkOutput("pace_w1_sum", laneSum(), 32'd153);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, pix(13, 0), 1'b0, acc);
      checkOutput($sformatf("pace_w1_hold_ready_%0d", k), acc, 1'b0);
      checkOutput($sformatf("pace_w1_hold_valid_%0d", k), win_valid, 1'b1);
      checkOutput($sformatf("pace_w1_hold_conv_rst_%0d", k), conv_rst, 1'b0);
      checkOutput($sformatf("pace_w1_hold_image2_%0d", k), image2, 24'h222120);
    end
    applyStimulus(1'b1, pix(13, 0), 1'b0, acc);
    checkOutput("pace_w1_expire_accept", acc, 1'b1);
    checkOutput("pace_w2_valid", win_valid, 1'b1);
    checkOutput("pace_w2_conv_rst", conv_rst, 1'b1);
    checkOutput("pace_w2_image2", image2, 24'h232221);
    calls = 0;
    acc   = 1'b0;
    while (!acc && calls < 30) begin
      applyStimulus(1'b1, pix(14, 0), 1'b0, acc);
      calls++;
    end
    checkOutput("pace_w2_hold_length", calls, 32'd11);
    checkOutput("pace_w3_image2", image2, 24'h242322);
  endtask
`else
  typedef struct {
    logic [23:0] i0;
    logic [23:0] i1;
    logic [23:0] i2;
  } win_t;

  typedef struct {
    logic        v;
    logic [7:0]  pixel;
    logic        rdy;
    logic        expWinValid;
    logic        expFrameDone;
    logic [23:0] exp0;
    logic [23:0] exp1;
    logic [23:0] exp2;
  } vec_t;

  win_t expWin[6];
  vec_t vecs[21];

  // Hand-computed windows of one frame, in output order.
  task automatic fillTables();
    int widx;
    int r;
    int c;
    expWin[0] = '{24'h020100, 24'h121110, 24'h222120};
    expWin[1] = '{24'h030201, 24'h131211, 24'h232221};
    expWin[2] = '{24'h040302, 24'h141312, 24'h242322};
    expWin[3] = '{24'h121110, 24'h222120, 24'h323130};
    expWin[4] = '{24'h131211, 24'h232221, 24'h333231};
    expWin[5] = '{24'h141312, 24'h242322, 24'h343332};
    widx = 0;
    for (int i = 0; i < 20; i++) begin
      r = i / W;
      c = i % W;
      vecs[i].v            = 1'b1;
      vecs[i].pixel        = pix(i, 0);
      vecs[i].rdy          = 1'b1;
      vecs[i].expWinValid  = (r >= 2) && (c >= 2);
      vecs[i].expFrameDone = 1'b0;
      vecs[i].exp0         = '0;
      vecs[i].exp1         = '0;
      vecs[i].exp2         = '0;
      if (vecs[i].expWinValid) begin
        vecs[i].exp0 = expWin[widx].i0;
        vecs[i].exp1 = expWin[widx].i1;
        vecs[i].exp2 = expWin[widx].i2;
        widx++;
      end
    end
    vecs[20] = '{v: 1'b0, pixel: 8'h00, rdy: 1'b1, expWinValid: 1'b0,
                 expFrameDone: 1'b1, exp0: 24'h0, exp1: 24'h0, exp2: 24'h0};
  endtask

  // Full frame with win_ready high, checked cycle by cycle from the table.
  task automatic runFrameTable();
    logic acc;
    int   baseWin;
    int   baseFd;
    baseWin = windowCount;
    baseFd  = frameDoneCount;
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].v, vecs[i].pixel, vecs[i].rdy, acc);
      if (vecs[i].v) checkOutput($sformatf("frame_accept_%0d", i), acc, 1'b1);
      checkOutput($sformatf("frame_win_valid_%0d", i), win_valid, vecs[i].expWinValid);
      checkOutput($sformatf("frame_done_%0d", i), frame_done, vecs[i].expFrameDone);
      if (vecs[i].expWinValid) begin
        checkOutput($sformatf("frame_image0_%0d", i), image0, vecs[i].exp0);
        checkOutput($sformatf("frame_image1_%0d", i), image1, vecs[i].exp1);
        checkOutput($sformatf("frame_image2_%0d", i), image2, vecs[i].exp2);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("frame_done_clears", frame_done, 1'b0);
    checkOutput("frame_window_count", windowCount - baseWin, 32'd6);
    checkOutput("frame_done_count", frameDoneCount - baseFd, 32'd1);
  endtask

  // Hold window 2 for five cycles, then release it while offering a pixel.
  task automatic runBackpressure();
    logic acc;
    int   baseWin;
    baseWin = windowCount;
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, pix(i, 0), 1'b1, acc);
    checkOutput("bp_w2_valid", win_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, pix(14, 0), 1'b0, acc);
      checkOutput($sformatf("bp_hold_accept_%0d", k), acc, 1'b0);
      checkOutput($sformatf("bp_hold_valid_%0d", k), win_valid, 1'b1);
      checkOutput($sformatf("bp_hold_image1_%0d", k), image1, 24'h131211);
      checkOutput($sformatf("bp_hold_image2_%0d", k), image2, 24'h232221);
    end
    applyStimulus(1'b1, pix(14, 0), 1'b1, acc);
    checkOutput("bp_release_accept", acc, 1'b1);
    checkOutput("bp_w3_valid", win_valid, 1'b1);
    checkOutput("bp_w3_image2", image2, 24'h242322);
    for (int i = 15; i < 20; i++) applyStimulus(1'b1, pix(i, 0), 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("bp_window_count", windowCount - baseWin, 32'd6);
  endtask

  // Reset after pixel 0x21, then restream and expect a clean first window.
  task automatic runResetMidFrame();
    logic acc;
    int   baseWin;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, pix(i, 0), 1'b1, acc);
    reset    = 1'b1;
    in_valid = 1'b0;
    #2;
    checkOutput("rst_mid_win_valid", win_valid, 1'b0);
    checkOutput("rst_mid_image0", image0, 24'h0);
    checkOutput("rst_mid_image1", image1, 24'h0);
    checkOutput("rst_mid_image2", image2, 24'h0);
    checkOutput("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    baseWin = windowCount;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, pix(i, 0), 1'b1, acc);
    checkOutput("rst_refill_no_window", win_valid, 1'b0);
    applyStimulus(1'b1, pix(12, 0), 1'b1, acc);
    checkOutput("rst_first_valid", win_valid, 1'b1);
    checkOutput("rst_first_image0", image0, expWin[0].i0);
    checkOutput("rst_first_image1", image1, expWin[0].i1);
    checkOutput("rst_first_image2", image2, expWin[0].i2);
    for (int i = 13; i < 20; i++) applyStimulus(1'b1, pix(i, 0), 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("rst_window_count", windowCount - baseWin, 32'd6);
  endtask

  // Two frames with no gap; frame two pixels carry a 0x40 offset.
  task automatic runBackToBack();
    logic acc;
    int   baseWin;
    int   baseFd;
    baseWin = windowCount;
    baseFd  = frameDoneCount;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, pix(i % 20, (i >= 20) ? 32'h40 : 32'h0), 1'b1, acc);
      if (i == 20) checkOutput("b2b_frame1_done", frame_done, 1'b1);
      if (i == 32) begin
        checkOutput("b2b_f2_first_valid", win_valid, 1'b1);
        checkOutput("b2b_f2_first_image0", image0, 24'h424140);
        checkOutput("b2b_f2_first_image1", image1, 24'h525150);
        checkOutput("b2b_f2_first_image2", image2, 24'h626160);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("b2b_window_count", windowCount - baseWin, 32'd12);
    checkOutput("b2b_frame_done_count", frameDoneCount - baseFd, 32'd2);
  endtask
`endif

  // Main sequence: reset checks, then the scenarios for this build.
  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_pixel     = 8'h00;
    win_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_win_valid", win_valid, 1'b0);
    checkOutput("reset_image0", image0, 24'h0);
    checkOutput("reset_image1", image1, 24'h0);
    checkOutput("reset_image2", image2, 24'h0);
    checkOutput("reset_conv_rst", conv_rst, 1'b0);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;
`ifdef CONV_WINGEN_PACE_EN
    runPace();
`else
    fillTables();
    runFrameTable();
    runBackpressure();
    runResetMidFrame();
    runBackToBack();
`endif
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
